// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the two-word opcode and redirect vectors.
package cpu_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        IMM   = 1'b1
    } fetch_state_e;

    localparam logic [3:0] OPC_IMM       = 4'd8;
    localparam int         CPU_RESET_VEC = 32;
    localparam int         CPU_INT_VEC   = 0;

endpackage

// File: rtl/fetch_pc_arbiter.sv
// Combinational PC redirect priority mux: exception, interrupt, pop_pc, jump, then sequential PC.
module fetch_pc_arbiter
    import cpu_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(CPU_RESET_VEC),
    parameter logic [PC_W-1:0] INT_VEC   = PC_W'(CPU_INT_VEC)
) (
    input  fetch_state_e    state,
    input  logic            int_pend,
    input  logic            exception,
    input  logic            pop_pc,
    input  logic [PC_W-1:0] pc_pop,
    input  logic            jmp,
    input  logic [PC_W-1:0] pc_jmp,
    input  logic [PC_W-1:0] pc_seq,
    output logic [PC_W-1:0] pc_next,
    output logic            redirect,
    output logic            int_take
);

    // Interrupts are only taken in FETCH so a two-word instruction is never split.
    always_comb begin
        pc_next  = pc_seq;
        redirect = 1'b0;
        int_take = 1'b0;
        if (exception) begin
            pc_next  = RESET_VEC;
            redirect = 1'b1;
        end else if (int_pend && state == FETCH) begin
            pc_next  = INT_VEC;
            redirect = 1'b1;
            int_take = 1'b1;
        end else if (pop_pc) begin
            pc_next  = pc_pop;
            redirect = 1'b1;
        end else if (jmp) begin
            pc_next  = pc_jmp;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with two-word immediate assembly and redirect arbitration.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 16,
    parameter int                 OPC_W     = 4,
    parameter logic [OPC_W-1:0]   IMM_OPC   = OPC_W'(OPC_IMM),
    parameter logic [PC_W-1:0]    RESET_VEC = PC_W'(CPU_RESET_VEC),
    parameter logic [PC_W-1:0]    INT_VEC   = PC_W'(CPU_INT_VEC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               interrupt,
    input  logic               set_int,
    input  logic               exception,
    input  logic               pop_pc,
    input  logic [PC_W-1:0]    pc_pop,
    input  logic               jmp,
    input  logic [PC_W-1:0]    pc_jmp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_imm,
    output logic [PC_W-1:0]    out_pc_ret,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls,
`endif
    output logic               out_int
);

    fetch_state_e       state, state_next;
    logic [PC_W-1:0]    pc, pc_inc, pc_seq, pc_next;
    logic [INSTR_W-1:0] hold;
    logic               hold_load;
    logic               int_pend;
    logic               bundle_valid;
    logic               redirect, int_take;
    logic               is_imm;

    assign pc_inc     = pc + PC_W'(1);
    assign is_imm     = (imem_rdata[INSTR_W-1 -: OPC_W] == IMM_OPC);
    assign imem_addr  = pc;
    assign out_pc_ret = pc_inc;

    fetch_pc_arbiter #(
        .PC_W      (PC_W),
        .RESET_VEC (RESET_VEC),
        .INT_VEC   (INT_VEC)
    ) u_arbiter (
        .state     (state),
        .int_pend  (int_pend),
        .exception (exception),
        .pop_pc    (pop_pc),
        .pc_pop    (pc_pop),
        .jmp       (jmp),
        .pc_jmp    (pc_jmp),
        .pc_seq    (pc_seq),
        .pc_next   (pc_next),
        .redirect  (redirect),
        .int_take  (int_take)
    );

    // The FETCH->IMM step ignores out_ready: the first word is never presented alone.
    always_comb begin
        state_next   = state;
        pc_seq       = pc;
        hold_load    = 1'b0;
        bundle_valid = 1'b0;
        out_instr    = imem_rdata;
        out_imm      = '0;
        unique case (state)
            FETCH: begin
                if (is_imm) begin
                    hold_load  = 1'b1;
                    pc_seq     = pc_inc;
                    state_next = IMM;
                end else begin
                    bundle_valid = 1'b1;
                    if (out_ready) pc_seq = pc_inc;
                end
            end
            IMM: begin
                bundle_valid = 1'b1;
                out_instr    = hold;
                out_imm      = reset ? '0 : imem_rdata;
                if (out_ready) begin
                    pc_seq     = pc_inc;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        if (redirect) state_next = FETCH;
    end

    assign out_valid = bundle_valid & ~redirect & ~reset;
    assign out_int   = int_take & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_VEC;
            state    <= FETCH;
            int_pend <= 1'b0;
            hold     <= '0;
        end else begin
            pc       <= pc_next;
            state    <= state_next;
            int_pend <= (int_pend & ~int_take) | interrupt | set_int;
            if (redirect)       hold <= '0;
            else if (hold_load) hold <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (out_valid && out_ready && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (out_valid && !out_ready && perf_stalls != 32'hFFFF_FFFF)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs driven on negedge, outputs checked 1ns later.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        interrupt, set_int, exception, pop_pc, jmp, out_ready;
    logic [31:0] pc_pop, pc_jmp;
    logic        out_valid, out_int;
    logic [15:0] out_instr, out_imm;
    logic [31:0] out_pc_ret;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stalls;
`endif

    logic [15:0] imem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[7:0]];

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .interrupt  (interrupt),
        .set_int    (set_int),
        .exception  (exception),
        .pop_pc     (pop_pc),
        .pc_pop     (pc_pop),
        .jmp        (jmp),
        .pc_jmp     (pc_jmp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_imm    (out_imm),
        .out_pc_ret (out_pc_ret),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_stalls  (perf_stalls),
`endif
        .out_int    (out_int)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic intr, input logic si, input logic exc,
                                 input logic pop, input logic [31:0] ppop,
                                 input logic jv, input logic [31:0] pj);
        out_ready = rdy;
        interrupt = intr;
        set_int   = si;
        exception = exc;
        pop_pc    = pop;
        pc_pop    = ppop;
        jmp       = jv;
        pc_jmp    = pj;
        #1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h1000 + 16'(i);
        imem[32] = 16'h1234;
        imem[50] = 16'h8111;
        imem[51] = 16'h0222;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held for two rising edges
        nextCycle();
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_int", 32'(out_int), 0);
        checkOutput("rst_imm", 32'(out_imm), 0);
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("t1_addr", imem_addr, 32);
        checkOutput("t1_valid", 32'(out_valid), 1);
        checkOutput("t1_instr", 32'(out_instr), 32'h1234);
        checkOutput("t1_pcret", out_pc_ret, 33);

        // Two-word immediate instruction
        imem[32] = 16'h8ABC;
        imem[33] = 16'h0055;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_c1_valid", 32'(out_valid), 0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_c2_valid", 32'(out_valid), 1);
        checkOutput("t2_c2_instr", 32'(out_instr), 32'h8ABC);
        checkOutput("t2_c2_imm", 32'(out_imm), 32'h0055);
        checkOutput("t2_c2_pcret", out_pc_ret, 34);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_next_addr", imem_addr, 34);
        checkOutput("t2_next_imm", 32'(out_imm), 0);

        // Stall on a one-word instruction at 40
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 40);
        checkOutput("t3_jmp_valid", 32'(out_valid), 0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("t3_stall_addr", imem_addr, 40);
            checkOutput("t3_stall_instr", 32'(out_instr), 32'h1028);
            checkOutput("t3_stall_valid", 32'(out_valid), 1);
            nextCycle();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("t3_release_addr", imem_addr, 41);

        // Interrupt arriving while a two-word instruction is in flight
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 50);
        nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_c1_valid", 32'(out_valid), 0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_imm_valid", 32'(out_valid), 1);
        checkOutput("t4_imm_instr", 32'(out_instr), 32'h8111);
        checkOutput("t4_imm_imm", 32'(out_imm), 32'h0222);
        checkOutput("t4_imm_int", 32'(out_int), 0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_take_addr", imem_addr, 52);
        checkOutput("t4_take_int", 32'(out_int), 1);
        checkOutput("t4_take_valid", 32'(out_valid), 0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_vec_addr", imem_addr, 0);
        checkOutput("t4_vec_int", 32'(out_int), 0);

        // Exception beats a simultaneous jump
        applyStimulus(1, 0, 0, 1, 0, 0, 1, 100);
        checkOutput("t5_valid", 32'(out_valid), 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_addr", imem_addr, 32);

        // pop_pc while stalled in IMM
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_imm_addr", imem_addr, 33);
        checkOutput("t6_imm_valid", 32'(out_valid), 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 77, 0, 0);
        checkOutput("t6_stall_addr", imem_addr, 33);
        checkOutput("t6_pop_valid", 32'(out_valid), 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_pop_addr", imem_addr, 77);
        checkOutput("t6_pop_instr", 32'(out_instr), 32'h104D);
        checkOutput("t6_pop_valid2", 32'(out_valid), 1);

        // Interrupt together with exception stays pending
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
        checkOutput("t7_exc_int", 32'(out_int), 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t7_exc_addr", imem_addr, 32);
        checkOutput("t7_pend_int", 32'(out_int), 1);
        checkOutput("t7_pend_valid", 32'(out_valid), 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t7_vec_addr", imem_addr, 0);
        checkOutput("t7_cleared_int", 32'(out_int), 0);

        // PC wrap at all-ones
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t8_wrap_valid", 32'(out_valid), 1);
        checkOutput("t8_wrap_instr", 32'(out_instr), 32'h10FF);
        checkOutput("t8_wrap_pcret", out_pc_ret, 0);
        nextCycle();
        checkOutput("t8_wrap_addr", imem_addr, 0);

        // Software interrupt via set_int
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t9_si_valid", 32'(out_valid), 1);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t9_si_addr", imem_addr, 1);
        checkOutput("t9_si_int", 32'(out_int), 1);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t9_si_vec", imem_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
